fetch_stage: RTL

//  Fetch stage of the 5-stage pipeline: owns the PC and issues instruction-memory reads.
//  It presents instructionF/incPCF/errF to the F/D pipeline register and honours decode

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads and presents the fetched
// instruction to the F/D register, with decode stalls, execute redirects and HALT handling.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  output logic [15:0] instructionF,
  output logic [15:0] incPCF,
  output logic        errF,
  output logic        validF,
  output logic        haltF
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HALTED  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;

  logic misaligned;
  logic halt_hit;

  assign misaligned = pc_q[0];
  assign halt_hit   = (imem_data[15:11] == HALT_OPC) || imem_err;

  // State register.
  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pend_pc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state and PC update.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_en) begin
          if (imem_done || misaligned) begin
            pc_d = redirect_pc;
          end else begin
            // The in-flight access must finish at a stable address before we move on.
            pend_pc_d = redirect_pc;
            state_d   = S_DISCARD;
          end
        end else if (misaligned) begin
          if (!stallD) state_d = S_HALTED;
        end else if (imem_done && !stallD) begin
          pc_d = pc_q + 16'd2;
          if (halt_hit) state_d = S_HALTED;
        end
      end
      S_DISCARD: begin
        if (redirect_en) pend_pc_d = redirect_pc;
        if (imem_done) begin
          pc_d    = redirect_en ? redirect_pc : pend_pc_q;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs: combinational from state and memory response, no added latency.
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    instructionF = NOP_INSTR;
    incPCF       = pc_q + 16'd2;
    errF         = 1'b0;
    validF       = 1'b0;
    haltF        = 1'b0;
    if (!rst) begin
      incPCF = RESET_PC + 16'd2;
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_req = !misaligned;
          if (!redirect_en) begin
            if (misaligned) begin
              errF = 1'b1;
            end else if (imem_done) begin
              instructionF = imem_data;
              validF       = 1'b1;
              errF         = imem_err;
            end
          end
        end
        S_DISCARD: imem_req = 1'b1;
        S_HALTED:  haltF    = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule
